// File: rtl/xor_stream_descrambler.sv
// rtl/xor_stream_descrambler.sv - additive XOR word descrambler with a 24-bit Fibonacci LFSR keystream
// Optional parity check on the scrambled input word: define DESCRAMBLER_PARITY_CHECK_EN.
module xor_stream_descrambler #(
  parameter int                DATA_W         = 24,
  parameter logic [DATA_W-1:0] SEED           = 24'h5A5A5A,
  parameter int                STEPS_PER_WORD = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              reseed,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [15:0]       word_count
`ifdef DESCRAMBLER_PARITY_CHECK_EN
  ,
  input  logic              in_parity,
  output logic              parity_err
`endif
);

  logic [DATA_W-1:0] lfsr;
  logic              accept;

  // Reseed blocks acceptance so the transmitter and receiver restart on the same word.
  assign in_ready = (!out_valid || out_ready) && !reseed;
  assign accept   = in_valid && in_ready;

  // Taps 23,22,21,16; all steps for one word are unrolled into a single cycle.
  function automatic logic [DATA_W-1:0] lfsr_advance(input logic [DATA_W-1:0] s);
    logic [DATA_W-1:0] v;
    v = s;
    for (int i = 0; i < STEPS_PER_WORD; i++) begin
      v = {v[DATA_W-2:0], v[23] ^ v[22] ^ v[21] ^ v[16]};
    end
    return v;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr       <= SEED;
      word_count <= '0;
    end else if (reseed) begin
      lfsr       <= SEED;
      word_count <= '0;
    end else if (accept) begin
      lfsr       <= lfsr_advance(lfsr);
      word_count <= word_count + 16'd1;
    end
  end

  // Output stage is independent of reseed so a pending word still drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= in_data ^ lfsr;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef DESCRAMBLER_PARITY_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_err <= 1'b0;
    end else if (accept) begin
      parity_err <= (^in_data) ^ in_parity;
    end
  end
`endif

endmodule

// File: doc/xor_stream_descrambler.md
Name: xor_stream_descrambler

Overview:
- Receive end of the additive (XOR) word scrambler on the 24-bit datapath.
- Accepts scrambled 24-bit words over a valid/ready handshake.
- XORs each word with a keystream word from a 24-bit Fibonacci LFSR, then presents the plain word downstream through a one-entry registered output stage.
- The LFSR advances only on accepted words, so it stays in lockstep with the transmitter's scrambler while both start from the same seed.

Parameters:
- DATA_W, 24: word width. Fixed at 24; the LFSR taps are defined for 24 bits.
- SEED, 24'h5A5A5A: LFSR value after reset and after Reseed. Must be non-zero.
- STEPS_PER_WORD, 24: LFSR single-bit steps applied per accepted word (1..24).

Ports:
- Clock  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-low reset
- Reseed  in  1  synchronous: reload LFSR with SEED, clear WordCount
- InValid  in  1  upstream word valid
- InReady  out  1  descrambler can accept this cycle
- InData  in  24  scrambled word
- OutValid  out  1  OutData holds a plain word
- OutReady  in  1  downstream accepts OutData
- OutData  out  24  descrambled word
- WordCount  out  16  words accepted since reset/reseed

Behaviour:
- Reset (Reset=0, asynchronous): LFSR=SEED, OutValid=0, OutData=0, WordCount=0.
- Reset release is synchronous to Clock.
- LFSR single step (Fibonacci, shift left): new bit0 = S[23]^S[22]^S[21]^S[16]; S_next = {S[22:0], new bit0}.
- Keystream word = current LFSR state S, before advancing.
- Accept condition: InValid && InReady && !Reseed.
- InReady = (!OutValid || OutReady) && !Reseed. InReady is combinational and does not depend on InValid.
- On accept, at the next edge:
  - OutData <= InData ^ S
  - OutValid <= 1
  - S <= S stepped STEPS_PER_WORD times (computed combinationally in one cycle)
  - WordCount <= WordCount+1, wrapping 16'hFFFF -> 0
- Latency is one cycle from accept to OutValid.
- Full throughput: one word per cycle while OutReady=1.
- OutValid && OutReady without an accept: OutValid <= 0. OutData holds its last value.
- OutValid && !OutReady: OutData and OutValid hold. InReady=0 (backpressure). LFSR is frozen.
- Simultaneous drain and accept: the new word replaces the old one. OutValid stays 1, with no bubble.
- Reseed=1 (priority over accept):
  - S <= SEED, WordCount <= 0, no word accepted, InReady=0 that cycle.
  - The output stage is untouched: a pending OutData stays valid until drained.
- Reset asserted mid-stream: the pending output word is discarded and state returns to reset values immediately.
- InValid may drop without a transfer; the block holds no state for unaccepted words.
- LFSR never reaches zero from a non-zero SEED. No zero-lock recovery is required.

Optional Feature:
- Macro: DESCRAMBLER_PARITY_CHECK_EN.
- When defined:
  - Adds input InParity (1 bit, sampled with InData) and output ParityErr (1 bit, registered, reset 0).
  - On accept, ParityErr <= (^InData) ^ InParity, i.e. even parity over the scrambled word.
  - ParityErr is qualified by OutValid and holds alongside OutData.
  - A parity error does not stall or alter the data path or the LFSR.
- When undefined: neither port exists, and behaviour is otherwise identical.

Test Plan:
- Reset, then one word InData=24'h000000, OutReady=1 -> next cycle OutValid=1, OutData=24'h5A5A5A, WordCount=1.
- Stream 1000 random words from a golden scrambler model (SEED 24'h5A5A5A) with random InValid gaps -> OutData matches the original plaintext in order, WordCount=1000.
- Hold OutReady=0 for 5 cycles with InValid=1 -> InReady=0, OutData stable, LFSR unchanged. Release -> the next word is descrambled with the correct keystream and no word is lost or duplicated.
- Reseed pulsed while InValid=1 and an output is pending -> the pending word drains unchanged, the InValid word is not accepted that cycle, and the next accepted 24'h000000 gives OutData=24'h5A5A5A with WordCount=1.
- Assert Reset mid-stream with OutValid=1 -> OutValid=0, OutData=0, WordCount=0 immediately. After release the sequence restarts from SEED.
- With DESCRAMBLER_PARITY_CHECK_EN: InData=24'h000001, InParity=0 -> ParityErr=1. InData=24'h000001, InParity=1 -> ParityErr=0. Data is correct in both cases.
